// File: rtl/register_chain_loader_pkg.sv
// Shared definitions for the register-chain loader: FSM encoding, the
// length of the quiet cycle before the update pulse, and counter sizing.
package register_chain_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_UPDATE = 2'd3
   } state_e;

   // Quiet cycles between the last shift edge and the update edge.
   localparam int unsigned SETTLE_CYCLES = 1;

   // Counter width for a chain of n cells; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/register_chain_loader.sv
// Serial loader for a chain of register_cell instances.
// Takes a parallel word over a valid/ready handshake, shifts it into the
// chain MSB first, waits a quiet cycle, then pulses chain_update once.
// Optional readback of the previous chain contents is built when the
// macro REGISTER_CHAIN_READBACK_EN is defined; otherwise rb_data/rb_valid
// are tied to 0 and no capture flops exist.
//
// Handshake: a word is taken on a rising edge where load_valid and
// load_ready are both 1. load_ready is 1 only while idle; the host must
// keep load_valid and load_data stable until that edge. load_data is not
// looked at again after acceptance.
module register_chain_loader
   import register_chain_pkg::*;
#(
   parameter int CHAIN_LEN = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [CHAIN_LEN-1:0] load_data,
   output logic                 chain_in,
   output logic                 chain_enable,
   output logic                 chain_update,
   input  logic                 chain_sout,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] rb_data,
   output logic                 rb_valid,
   output logic [1:0]           dbg_state
);

   localparam int                CW          = int'(cnt_width(CHAIN_LEN));
   localparam logic [CW-1:0]     CNT_LAST    = CW'(CHAIN_LEN - 1);
   localparam logic [CW-1:0]     SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

   state_e                 state_q, state_d;
   logic [CHAIN_LEN-1:0]   shreg_q, shreg_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   // Registered outputs and their next values (computed from next state,
   // so every chain-facing output comes straight from a flop).
   logic                   ready_q, ready_d;
   logic                   cin_q, cin_d;
   logic                   cen_q, cen_d;
   logic                   cupd_q, cupd_d;
   logic                   done_q, done_d;

   logic                   accept;

   assign accept = (state_q == ST_IDLE) && load_valid && ready_q;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic plus shift register / counter updates.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SHIFT;
               shreg_d = load_data;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            shreg_d = shreg_q << 1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = ST_UPDATE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_UPDATE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state so the flops below hold this cycle's view.
   always_comb begin
      ready_d = (state_d == ST_IDLE);
      cen_d   = (state_d == ST_SHIFT);
      cin_d   = (state_d == ST_SHIFT) && shreg_d[CHAIN_LEN-1];
      cupd_d  = (state_d == ST_UPDATE);
      done_d  = (state_d == ST_UPDATE);
   end

   // Datapath and output registers; everything clears on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         cin_q   <= 1'b0;
         cen_q   <= 1'b0;
         cupd_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         cin_q   <= cin_d;
         cen_q   <= cen_d;
         cupd_q  <= cupd_d;
         done_q  <= done_d;
      end
   end

   assign load_ready   = ready_q;
   assign chain_in     = cin_q;
   assign chain_enable = cen_q;
   assign chain_update = cupd_q;
   assign done         = done_q;
   assign dbg_state    = state_q;

`ifdef REGISTER_CHAIN_READBACK_EN
   logic [CHAIN_LEN-1:0] rb_q, rb_d;
   logic                 rbv_q;

   // While shifting, the old chain contents fall out of the last cell;
   // collect them LSB-in so rb_q[i] ends up holding old cell i.
   always_comb begin
      rb_d = rb_q;
      if (state_q == ST_SHIFT) begin
         rb_d    = rb_q << 1;
         rb_d[0] = chain_sout;
      end
   end

   // Readback capture register and its valid pulse (aligned with done).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rb_q  <= '0;
         rbv_q <= 1'b0;
      end else begin
         rb_q  <= rb_d;
         rbv_q <= (state_d == ST_UPDATE);
      end
   end

   assign rb_data  = rb_q;
   assign rb_valid = rbv_q;
`else
   logic unused_chain_sout;
   assign unused_chain_sout = chain_sout;
   assign rb_data  = '0;
   assign rb_valid = 1'b0;
`endif

endmodule

// File: doc/register_chain_loader.md
Name: register_chain_loader

Overview:
- Upstream driver for a serial chain of register_cell instances.
- Accepts a parallel word over a valid/ready handshake and shifts it serially into the chain, MSB first.
- Then issues a single update pulse so every cell transfers its shifted bit to bit_out.
- Sits between the host/config logic and cell 0 of the chain; the last cell's chain_out returns to the loader for optional readback.

Parameters:
- CHAIN_LEN, 8, number of register_cell stages in the chain (legal range 1..256).

Ports:
- clk  input  1  single clock; also drives the clk pin of every chain cell.
- reset  input  1  asynchronous, active-low reset.
- load_valid  input  1  host offers load_data.
- load_ready  output  1  loader idle and able to accept a word.
- load_data  input  CHAIN_LEN  word to program; bit i ends in cell i (cell 0 is nearest the loader).
- chain_in  output  1  serial data into cell 0.
- chain_enable  output  1  drives every cell's enable; 1 = shift, 0 = hold (recirculate).
- chain_update  output  1  drives every cell's update pin.
- chain_sout  input  1  chain_out of cell CHAIN_LEN-1.
- done  output  1  one-cycle pulse when the update has been issued.
- rb_data  output  CHAIN_LEN  previous chain contents (readback feature).
- rb_valid  output  1  one-cycle pulse, rb_data valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE; shift register, counter and rb_data cleared.
  - chain_in, chain_enable, chain_update, done and rb_valid all 0.
  - load_ready goes to 1 after reset release (IDLE).
- All chain-facing outputs are registered, with no combinational path from inputs.
- FSM states: IDLE, SHIFT, SETTLE, UPDATE.
- IDLE:
  - load_ready=1.
  - On load_valid && load_ready at edge t: latch load_data into the shift register, clear the counter, go to SHIFT.
- SHIFT:
  - Covers cycles t+1 .. t+CHAIN_LEN.
  - chain_enable=1; chain_in = shift-register MSB; shift left by one each cycle; counter increments.
  - Leave SHIFT when counter == CHAIN_LEN-1. chain_enable is high for exactly CHAIN_LEN cycles.
  - Sent bit order: load_data[CHAIN_LEN-1] first, load_data[0] last.
- SETTLE:
  - Cycle t+CHAIN_LEN+1; chain_enable=0 and chain_in=0.
  - Gives one quiet cycle so each cell's internal data is stable before the update edge.
- UPDATE:
  - Cycle t+CHAIN_LEN+2; chain_update=1 for exactly this one cycle; done=1 in the same cycle.
  - Next state is IDLE; load_ready returns to 1 in cycle t+CHAIN_LEN+3.
- load_ready=0 in SHIFT, SETTLE and UPDATE. load_valid is ignored there and the host must hold it.
- Minimum back-to-back spacing between accepted words: CHAIN_LEN+3 cycles.
- Counter width is $clog2(CHAIN_LEN) with a minimum of 1 bit.
- CHAIN_LEN=1: SHIFT lasts one cycle and the counter terminal value is 0.
- Reset mid-operation:
  - All outputs drop to 0 immediately; no update pulse is issued.
  - Chain contents are undefined; the host must reload.
- load_data changing after acceptance has no effect.

Optional Feature:
- Macro: REGISTER_CHAIN_READBACK_EN.
- With the macro:
  - At each SHIFT-cycle posedge, sample chain_sout into rb_data LSB and shift rb_data left.
  - The k-th sample is the old content of cell CHAIN_LEN-1-k, so after SHIFT rb_data[i] = previous cell i content.
  - rb_valid pulses in the UPDATE cycle, together with done.
  - rb_data holds its value until the next SHIFT begins.
- Without the macro: the rb_data and rb_valid ports remain and are tied to 0; no capture flops are generated.

Decomposition:
- Shared package register_chain_pkg holds:
  - typedef enum for the FSM states (IDLE, SHIFT, SETTLE, UPDATE);
  - constant SETTLE_CYCLES=1;
  - a function computing the counter width from CHAIN_LEN.
- Single module; no sub-module is warranted.
- The bench reuses register_cell as the chain model (CHAIN_LEN instances).

Test Plan:
- Reset asserted with load_valid=1 -> all outputs 0, load_ready=0; after release load_ready=1 and no chain_enable activity.
- CHAIN_LEN=8, load 0xA5 at edge t:
  - chain_enable high cycles t+1..t+8; chain_in 1,0,1,0,0,1,0,1;
  - chain_update and done high in cycle t+10 only; chain bit_out = 0xA5.
- load_valid held with 0xFF then 0x00:
  - second word accepted at edge t+11;
  - exactly two update pulses; final bit_out = 0x00.
- READBACK_EN, load 0x3C then 0xC3 -> rb_data=0x3C with rb_valid in the same cycle as the second done; bit_out=0xC3.
- Reset pulsed during SHIFT cycle t+4 after loading 0xFF:
  - chain_enable and chain_update stay 0, with no done;
  - a following 0x5A load yields bit_out=0x5A.
- CHAIN_LEN=1, load 1'b1 -> chain_enable for one cycle (t+1), update at t+3, bit_out=1.
